// File: rtl/input_capture_ctrl_pkg.sv
// Shared definitions for the input capture controller: FSM encoding,
// board button indices and the button-code width helper.
package input_capture_defs;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cap_state_e;

    localparam int BTN_N_IDX = 0;
    localparam int BTN_E_IDX = 1;
    localparam int BTN_S_IDX = 2;
    localparam int BTN_W_IDX = 3;

    // Width of btn_code; callers guarantee at least two buttons.
    function automatic int btn_code_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/input_capture_ctrl_btn_debounce.sv
// One button lane: two-flop synchroniser, stable-count debouncer and
// rising-edge detector on the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic deb_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             deb_q;
    logic             deb_d;
    logic             debPrev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            deb_q     <= 1'b0;
            debPrev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            meta_q    <= btn_i;
            sync_q    <= meta_q;
            deb_q     <= deb_d;
            debPrev_q <= deb_q;
            cnt_q     <= cnt_d;
        end
    end

    assign deb_o  = deb_q;
    assign rise_o = deb_q & ~debPrev_q;

endmodule

// File: rtl/input_capture_ctrl.sv
// Board input capture: merges the held base word with synchronised switches
// and turns debounced button presses into acknowledged events.
module input_capture_ctrl
    import input_capture_defs::*;
#(
    parameter int DATA_W          = 8,
    parameter int SW_W            = 4,
    parameter int BTN_N           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic [SW_W-1:0]               sw,
    input  logic [BTN_N-1:0]              btn,
    input  logic [DATA_W-1:0]             OldData,
    input  logic                          WriteToOldData,
    input  logic                          rd_ack,
    output logic [DATA_W-1:0]             O,
    output logic                          valid,
    output logic [btn_code_w(BTN_N)-1:0]  btn_code,
    output logic [DATA_W-1:0]             snap,
    output logic                          overflow
);

    localparam int BTN_W = btn_code_w(BTN_N);

    logic [SW_W-1:0]   swMeta_q;
    logic [SW_W-1:0]   swSync_q;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] o_q;
    logic [DATA_W-1:0] merged;
    logic [BTN_N-1:0]  deb;
    logic [BTN_N-1:0]  rise;
    logic [BTN_W-1:0]  firstIdx;
    logic              anyRise;
    logic              multiRise;
    cap_state_e        state_q, state_d;
    logic [BTN_W-1:0]  code_q, code_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic              ovf_q, ovf_d;

    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i (CLK),
            .rst_i (CLR),
            .btn_i (btn[gi]),
            .deb_o (deb[gi]),
            .rise_o(rise[gi])
        );
    end

    assign merged = base_q | DATA_W'(swSync_q);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            swMeta_q <= '0;
            swSync_q <= '0;
            base_q   <= '0;
            o_q      <= '0;
        end else begin
            swMeta_q <= sw;
            swSync_q <= swMeta_q;
            if (WriteToOldData) begin
                base_q <= OldData;
            end
            o_q <= (|deb) ? '0 : merged;
        end
    end

    // Lowest index wins; any further simultaneous rise is a dropped event.
    always_comb begin
        firstIdx = '0;
        for (int i = BTN_N - 1; i >= 0; i--) begin
            if (rise[i]) begin
                firstIdx = BTN_W'(i);
            end
        end
        anyRise   = |rise;
        multiRise = |(rise & (rise - BTN_N'(1)));
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (anyRise) begin
                    state_d = PEND;
                    code_d  = firstIdx;
                    snap_d  = merged;
                    if (multiRise) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            PEND: begin
                if (anyRise) begin
                    if (rd_ack) begin
                        code_d = firstIdx;
                        snap_d = merged;
                        if (multiRise) begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (rd_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            code_q  <= '0;
            snap_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign O        = o_q;
    assign valid    = (state_q == PEND);
    assign btn_code = code_q;
    assign snap     = snap_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_input_capture_ctrl.sv
// Randomised and directed bench for input_capture_ctrl with a cycle-level
// reference model feeding a scoreboard that a separate monitor drains.
module tb_input_capture_ctrl;

    localparam int DATA_W = 8;
    localparam int SW_W   = 4;
    localparam int BTN_N  = 4;
    localparam int DEB    = 4;
    localparam int BTN_W  = $clog2(BTN_N);

    logic              CLK = 1'b0;
    logic              CLR = 1'b1;
    logic [SW_W-1:0]   sw = '0;
    logic [BTN_N-1:0]  btn = '0;
    logic [DATA_W-1:0] OldData = '0;
    logic              WriteToOldData = 1'b0;
    logic              rd_ack = 1'b0;
    logic [DATA_W-1:0] O;
    logic              valid;
    logic [BTN_W-1:0]  btn_code;
    logic [DATA_W-1:0] snap;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    input_capture_ctrl #(
        .DATA_W(DATA_W), .SW_W(SW_W), .BTN_N(BTN_N), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLK(CLK), .CLR(CLR), .sw(sw), .btn(btn), .OldData(OldData),
        .WriteToOldData(WriteToOldData), .rd_ack(rd_ack), .O(O), .valid(valid),
        .btn_code(btn_code), .snap(snap), .overflow(overflow)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic [BTN_W-1:0]  code;
        logic [DATA_W-1:0] snap;
    } ev_t;

    typedef struct {
        logic [DATA_W-1:0] o;
        logic              v;
        logic              ovf;
    } cyc_t;

    ev_t  evQ[$];
    cyc_t cycQ[$];

    logic [SW_W-1:0]   mSw1 = '0, mSw2 = '0;
    logic [BTN_N-1:0]  mBtn1 = '0, mBtn2 = '0, mDeb = '0, mDebPrev = '0;
    int                mRun[BTN_N];
    logic [DATA_W-1:0] mBase = '0, mO = '0;
    logic              mPend = 1'b0, mOvf = 1'b0;
    logic              ackSampled = 1'b0;
    logic              prevValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a button level is accepted once the synchronised input
    // has disagreed with it for DEB samples in a row; events follow the
    // pending/ack rules with lowest-index priority.
    initial begin : refModel
        logic [BTN_N-1:0]  rise;
        logic [DATA_W-1:0] merged;
        int                nRise;
        int                first;
        forever begin
            @(posedge CLK);
            if (CLR) begin
                mSw1 = '0; mSw2 = '0; mBtn1 = '0; mBtn2 = '0;
                mDeb = '0; mDebPrev = '0; mBase = '0; mO = '0;
                mPend = 1'b0; mOvf = 1'b0;
                for (int i = 0; i < BTN_N; i++) mRun[i] = 0;
                evQ.delete();
            end else begin
                rise   = mDeb & ~mDebPrev;
                merged = mBase | DATA_W'(mSw2);
                nRise  = $countones(rise);
                first  = 0;
                for (int i = BTN_N - 1; i >= 0; i--) if (rise[i]) first = i;
                mO = (mDeb != '0) ? '0 : merged;
                if (nRise > 0 && (!mPend || rd_ack)) begin
                    evQ.push_back('{code: BTN_W'(first), snap: merged});
                    mPend = 1'b1;
                    if (nRise > 1) mOvf = 1'b1;
                end else if (nRise > 0) begin
                    mOvf = 1'b1;
                end else if (mPend && rd_ack) begin
                    mPend = 1'b0;
                end
                mDebPrev = mDeb;
                for (int i = 0; i < BTN_N; i++) begin
                    if (mBtn2[i] != mDeb[i]) mRun[i]++;
                    else mRun[i] = 0;
                    if (mRun[i] == DEB) begin
                        mDeb[i] = ~mDeb[i];
                        mRun[i] = 0;
                    end
                end
                mBtn2 = mBtn1; mBtn1 = btn;
                mSw2 = mSw1; mSw1 = sw;
                if (WriteToOldData) mBase = OldData;
            end
            ackSampled = rd_ack;
            cycQ.push_back('{o: mO, v: mPend, ovf: mOvf});
        end
    end

    // Monitor: per-cycle outputs, plus one scoreboard pop per presented event.
    initial begin : monitor
        cyc_t c;
        ev_t  e;
        forever begin
            @(negedge CLK);
            if (cycQ.size() > 0) begin
                c = cycQ.pop_front();
                checkOutput("O", 32'(O), 32'(c.o));
                checkOutput("valid", 32'(valid), 32'(c.v));
                checkOutput("overflow", 32'(overflow), 32'(c.ovf));
            end
            if (valid === 1'b1 && (!prevValid || ackSampled)) begin
                if (evQ.size() == 0) begin
                    checkOutput("event_unexpected", 32'(valid), 32'd0);
                end else begin
                    e = evQ.pop_front();
                    checkOutput("ev_btn_code", 32'(btn_code), 32'(e.code));
                    checkOutput("ev_snap", 32'(snap), 32'(e.snap));
                end
            end
            prevValid = (valid === 1'b1);
        end
    end

    task automatic applyStimulus(input logic [BTN_N-1:0] b, input int cycles);
        btn = b;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic ackPulse();
        rd_ack = 1'b1;
        @(negedge CLK);
        rd_ack = 1'b0;
    endtask

    task automatic loadBase(input logic [DATA_W-1:0] d);
        OldData = d;
        WriteToOldData = 1'b1;
        @(negedge CLK);
        WriteToOldData = 1'b0;
    endtask

    initial begin : stimulus
        $display("[TB] start");
        repeat (3) @(negedge CLK);
        checkOutput("reset_O", 32'(O), 32'h0);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        CLR = 1'b0;

        loadBase(8'h88);
        sw = 4'b0011;
        repeat (4) @(negedge CLK);
        checkOutput("merge_O", 32'(O), 32'h8B);
        checkOutput("merge_valid", 32'(valid), 32'h0);

        applyStimulus(4'b1000, 10);
        checkOutput("wb_O_zero", 32'(O), 32'h0);
        checkOutput("wb_valid", 32'(valid), 32'h1);
        checkOutput("wb_code", 32'(btn_code), 32'h3);
        checkOutput("wb_snap", 32'(snap), 32'h8B);
        applyStimulus(4'b0000, 8);
        checkOutput("wb_release_O", 32'(O), 32'h8B);
        ackPulse();
        checkOutput("wb_ack_valid", 32'(valid), 32'h0);

        applyStimulus(4'b0001, 3);
        applyStimulus(4'b0000, 10);
        checkOutput("glitch_valid", 32'(valid), 32'h0);
        checkOutput("glitch_O", 32'(O), 32'h8B);
        checkOutput("glitch_ovf", 32'(overflow), 32'h0);

        applyStimulus(4'b0001, 8);
        applyStimulus(4'b0000, 8);
        checkOutput("nb_code", 32'(btn_code), 32'h0);
        applyStimulus(4'b0010, 8);
        applyStimulus(4'b0000, 8);
        checkOutput("eb_drop_ovf", 32'(overflow), 32'h1);
        checkOutput("eb_drop_code", 32'(btn_code), 32'h0);
        ackPulse();
        checkOutput("ack_valid", 32'(valid), 32'h0);
        applyStimulus(4'b0001, 8);
        applyStimulus(4'b0000, 8);
        applyStimulus(4'b0100, 6);
        ackPulse();
        checkOutput("b2b_valid", 32'(valid), 32'h1);
        checkOutput("b2b_code", 32'(btn_code), 32'h2);
        applyStimulus(4'b0000, 8);

        sw = '0;
        repeat (3) @(negedge CLK);
        #2 CLR = 1'b1;
        #1;
        checkOutput("areset_O", 32'(O), 32'h0);
        checkOutput("areset_valid", 32'(valid), 32'h0);
        checkOutput("areset_ovf", 32'(overflow), 32'h0);
        @(negedge CLK);
        CLR = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("post_reset_O", 32'(O), 32'h0);

        loadBase(8'h5A);
        sw = 4'b0101;
        repeat (4) @(negedge CLK);
        applyStimulus(4'b0110, 8);
        applyStimulus(4'b0000, 8);
        checkOutput("simul_code", 32'(btn_code), 32'h1);
        checkOutput("simul_ovf", 32'(overflow), 32'h1);
        checkOutput("simul_snap", 32'(snap), 32'h5F);
        ackPulse();

        for (int n = 0; n < 60; n++) begin
            btn = BTN_N'($urandom);
            sw  = SW_W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                OldData = DATA_W'($urandom);
                WriteToOldData = 1'b1;
            end
            for (int k = $urandom_range(1, 8); k > 0; k--) begin
                rd_ack = ($urandom_range(0, 3) == 0);
                @(negedge CLK);
                WriteToOldData = 1'b0;
            end
        end
        btn = '0;
        rd_ack = 1'b0;
        repeat (12) @(negedge CLK);
        checkOutput("scoreboard_drained", 32'(evQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
